// File: rtl/part_dpram_gen_if.sv
// part_dpram_gen_if: two-port RAM bus bundle (address/data/enables/read results) plus init status
interface part_dpram_gen_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15
);
  localparam int BE_W = DATA_W / 8;
  logic init_done;
  logic [ADDR_W-1:0] address_a, address_b;
  logic [DATA_W-1:0] data_a, data_b, q_a, q_b;
  logic [BE_W-1:0] be_a, be_b;
  logic wren_a, wren_b, rden_a, rden_b, q_valid_a, q_valid_b;
  modport master (
    output address_a, data_a, be_a, wren_a, rden_a, address_b, data_b, be_b, wren_b, rden_b,
    input q_a, q_valid_a, q_b, q_valid_b, init_done
  );
  modport slave (
    input address_a, data_a, be_a, wren_a, rden_a, address_b, data_b, be_b, wren_b, rden_b,
    output q_a, q_valid_a, q_b, q_valid_b, init_done
  );
endinterface

// File: rtl/part_dpram_gen.sv
// part_dpram_gen: true dual-port RAM with byte enables, 1/2-cycle reads and post-reset zero-fill
module part_dpram_gen #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15,
  parameter int DEPTH = 21504,
  parameter int RD_LAT = 1,
  parameter int RDW_MODE = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic clk,
  input logic reset_n,
  part_dpram_gen_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [1:0] S_RESET = 2'd0, S_CLEAR = 2'd1, S_READY = 2'd2;
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("part_dpram_gen: RD_LAT must be 1 or 2");
  end
  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0] state;
  logic [IW-1:0] cnt;
  logic ready, sweep;
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] din [2], old [2], rdata [2], d1 [2], q [2];
  logic [BE_W-1:0] be [2];
  logic wr [2], rd [2], we [2], re [2], in_rng [2], v1 [2], qv [2];
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] o, input logic [DATA_W-1:0] d,
                                              input logic [BE_W-1:0] b);
    for (int i = 0; i < BE_W; i++) o[8*i +: 8] = b[i] ? d[8*i +: 8] : o[8*i +: 8];
    return o;
  endfunction
  assign addr[0] = bus.address_a;
  assign addr[1] = bus.address_b;
  assign din[0] = bus.data_a;
  assign din[1] = bus.data_b;
  assign be[0] = bus.be_a;
  assign be[1] = bus.be_b;
  assign wr[0] = bus.wren_a;
  assign wr[1] = bus.wren_b;
  assign rd[0] = bus.rden_a;
  assign rd[1] = bus.rden_b;
  assign bus.q_a = q[0];
  assign bus.q_b = q[1];
  assign bus.q_valid_a = qv[0];
  assign bus.q_valid_b = qv[1];
  assign bus.init_done = ready;
  assign ready = state == S_READY;
  // The sweep owns the array until READY, so it never races a port write.
  assign sweep = reset_n && CLEAR_ON_RESET != 0 && !ready;
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= S_RESET;
      cnt <= '0;
    end else if (!ready) begin
      state <= (CLEAR_ON_RESET == 0 || cnt == IW'(DEPTH - 1)) ? S_READY : S_CLEAR;
      cnt <= cnt + IW'(1);
    end
  always_comb
    for (int p = 0; p < 2; p++) begin
      we[p] = ready && wr[p];
      re[p] = ready && rd[p];
      in_rng[p] = {1'b0, addr[p]} < (ADDR_W + 1)'(DEPTH);
      old[p] = in_rng[p] ? mem[addr[p][IW-1:0]] : '0;
      rdata[p] = (we[p] && in_rng[p] && RDW_MODE == 0) ? merge(old[p], din[p], be[p]) : old[p];
    end
  // Port B lanes are applied first so port A overrides them on a same-address collision.
  always_ff @(posedge clk) begin
    if (sweep) mem[cnt] <= '0;
    for (int p = 1; p >= 0; p--)
      for (int i = 0; i < BE_W; i++)
        if (we[p] && in_rng[p] && be[p][i]) mem[addr[p][IW-1:0]][8*i +: 8] <= din[p][8*i +: 8];
  end
  always_ff @(posedge clk)
    for (int p = 0; p < 2; p++)
      if (!reset_n) begin
        d1[p] <= '0;
        v1[p] <= 1'b0;
        q[p] <= '0;
        qv[p] <= 1'b0;
      end else begin
        d1[p] <= re[p] ? rdata[p] : d1[p];
        v1[p] <= re[p];
        q[p] <= RD_LAT == 1 ? (re[p] ? rdata[p] : q[p]) : (v1[p] ? d1[p] : q[p]);
        qv[p] <= RD_LAT == 1 ? re[p] : v1[p];
      end
endmodule
